mips_mem_responder: RTL and testbench
=====================================

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 Parameter WIDTH, default 8: data and address width.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles inserted before each response (0..7).
REQ-003 Parameter OUTADR, default 8'hFF: address of the memory-mapped result port.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 memread  in  1  CPU read request, held until memready.
REQ-007 memwrite  in  1  CPU write request, held until memready.
REQ-008 adr  in  WIDTH  request address.
REQ-009 writedata  in  WIDTH  write data, valid with memwrite.
REQ-010 memdata  out  WIDTH  registered read data, valid while memready is high for a read.
REQ-011 memready  out  1  one-cycle completion pulse for the current request.
REQ-012 outport  out  WIDTH  last value written to OUTADR.
REQ-013 outvalid  out  1  one-cycle pulse, coincident with memready, on a write to OUTADR.
REQ-014 err  out  1  sticky flag: memread and memwrite sampled high together.
REQ-015 ldr_en, ldr_adr, ldr_data  in  1/WIDTH/WIDTH  program preload write port.

Function
REQ-016 Storage: 2^WIDTH x WIDTH array; contents are not cleared by reset.
REQ-017 FSM states: IDLE, WAIT, RESP; IDLE is the reset state.
REQ-018 IDLE: when memread or memwrite is high, latch adr, writedata and the op; go to WAIT if WAIT_STATES>0, else to RESP.
REQ-019 WAIT: 3-bit counter loaded with WAIT_STATES-1 on acceptance; decrement each cycle; go to RESP at 0.
REQ-020 RESP: assert memready for exactly one cycle, then return to IDLE.
REQ-021 Read: memdata = array[latched adr], registered on entry to RESP.
REQ-022 Write: array[latched adr] written on the RESP cycle.
REQ-023 Latency: memready rises WAIT_STATES+1 cycles after the acceptance edge.
REQ-024 The requester deasserts on the cycle after memready; a request seen in IDLE is always a new request.
REQ-025 memdata holds its last read value until the next read completes.
REQ-026 Write to OUTADR: the array is written, outport is updated on the RESP edge, and outvalid pulses with memready.
REQ-027 Simultaneous memread and memwrite in IDLE: set err and execute as a write.
REQ-028 Changes to adr or writedata after acceptance are ignored.
REQ-029 Loader: an ldr_en write is performed only in IDLE with no CPU request; otherwise it is silently dropped.
REQ-030 Address wrap: none; the full 2^WIDTH space is valid.

Reset
REQ-031 Reset low forces state to IDLE, counter to 0, and memdata, memready, outport, outvalid and err to 0, all asynchronously.
REQ-032 Reset asserted mid-request aborts the request; no array write occurs for it.
REQ-033 Deassertion is synchronized by the user; the first request is accepted on the first rising edge with reset high.

Structure
REQ-034 The shared package holds WIDTH, OUTADR and the FSM state encodings, which are shared with full_mips benches.
REQ-035 Sub-module mips_ram: synchronous-write, combinational-read array with one write port muxed between CPU and loader.
REQ-036 FSM, counter, output-port logic and err reside in mips_mem_responder.

Verification
REQ-037 Preload 8'h10=8'h5A via loader, then read 8'h10 with WAIT_STATES=1 -> memready 2 cycles after acceptance, memdata=8'h5A.
REQ-038 Write 8'h0D to 8'hFF -> outport=8'h0D, outvalid and memready pulse together for 1 cycle; a later read of 8'hFF returns 8'h0D.
REQ-039 WAIT_STATES=0, back-to-back reads of 8'h00 then 8'h01 -> each memready 1 cycle after acceptance; no lost or duplicated response.
REQ-040 memread=memwrite=1, adr=8'h20, writedata=8'h33 -> err=1 and stays set; array[8'h20]=8'h33.
REQ-041 Reset low during WAIT of a write of 8'hAA to 8'h30 -> no memready; array[8'h30] unchanged; all outputs 0.
REQ-042 ldr_en pulsed while a request is in WAIT -> loader write dropped; target address retains its prior value.

Source files
------------

// File: rtl/mips_mem_responder_pkg.sv
// Shared constants and FSM encodings for the MIPS memory responder and its benches.
package mips_mem_responder_pkg;

    localparam int         MEM_WIDTH  = 8;
    localparam logic [7:0] MEM_OUTADR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

    // Value loaded into the wait counter when a request is accepted.
    // It is clamped to zero for configurations without wait states.
    function automatic logic [2:0] wait_load(input int wait_states);
        if (wait_states > 0) begin
            return 3'(wait_states - 1);
        end else begin
            return 3'd0;
        end
    endfunction

endpackage

// File: rtl/mips_mem_responder_ram.sv
// Storage array: synchronous write, combinational read, one write port
// shared by the CPU (priority) and the program loader.
module mips_ram
    import mips_mem_responder_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
    input  logic             cpu_we_i,
    input  logic [WIDTH-1:0] cpu_adr_i,
    input  logic [WIDTH-1:0] cpu_data_i,
    input  logic             ldr_we_i,
    input  logic [WIDTH-1:0] ldr_adr_i,
    input  logic [WIDTH-1:0] ldr_data_i,
    input  logic [WIDTH-1:0] rd_adr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**WIDTH];
    logic             we_s;
    logic [WIDTH-1:0] wadr_s;
    logic [WIDTH-1:0] wdata_s;

    // Select the write port source; the CPU always wins over the loader.
    always_comb begin
        we_s    = 1'b0;
        wadr_s  = cpu_adr_i;
        wdata_s = cpu_data_i;
        if (cpu_we_i) begin
            we_s = 1'b1;
        end else if (ldr_we_i) begin
            we_s    = 1'b1;
            wadr_s  = ldr_adr_i;
            wdata_s = ldr_data_i;
        end else begin
            we_s = 1'b0;
        end
    end

    // Array write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[wadr_s] <= wdata_s;
        end
    end

    assign rd_data_o = mem_q[rd_adr_i];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for a multicycle MIPS core: request FSM with programmable
// wait states, registered read data, memory-mapped output port and error flag.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int               WIDTH       = MEM_WIDTH,
    parameter int               WAIT_STATES = 1,
    parameter logic [WIDTH-1:0] OUTADR      = WIDTH'(MEM_OUTADR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             memready,
    output logic [WIDTH-1:0] outport,
    output logic             outvalid,
    output logic             err,
    input  logic             ldr_en,
    input  logic [WIDTH-1:0] ldr_adr,
    input  logic [WIDTH-1:0] ldr_data
);

    localparam logic [2:0] CNT_LOAD = wait_load(WAIT_STATES);

    mem_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] adr_q, adr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             opwr_q, opwr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] memdata_q, memdata_d;
    logic             memready_q, memready_d;
    logic [WIDTH-1:0] outport_q, outport_d;
    logic             outvalid_q, outvalid_d;
    logic             ldr_we_s;
    logic             cpu_we_s;
    logic             enter_resp_s;
    logic             out_hit_s;
    logic [WIDTH-1:0] ram_rdata_s;

    // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        opwr_d   = opwr_q;
        err_d    = err_q;
        ldr_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memread || memwrite) begin
                    adr_d   = adr;
                    wdata_d = writedata;
                    opwr_d  = memwrite;
                    err_d   = err_q | (memread & memwrite);
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    ldr_we_s = ldr_en;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output next values, all captured on the edge that enters RESP.
    always_comb begin
        enter_resp_s = (state_d == ST_RESP);
        out_hit_s    = enter_resp_s && opwr_d && (adr_d == OUTADR);
        memready_d   = enter_resp_s;
        outvalid_d   = out_hit_s;
        if (enter_resp_s && !opwr_d) begin
            memdata_d = ram_rdata_s;
        end else begin
            memdata_d = memdata_q;
        end
        if (out_hit_s) begin
            outport_d = wdata_d;
        end else begin
            outport_d = outport_q;
        end
    end

    // The array write happens on the RESP edge, so an aborted request never writes.
    assign cpu_we_s = (state_q == ST_RESP) && opwr_q;

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            adr_q      <= '0;
            wdata_q    <= '0;
            opwr_q     <= 1'b0;
            err_q      <= 1'b0;
            memdata_q  <= '0;
            memready_q <= 1'b0;
            outport_q  <= '0;
            outvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            opwr_q     <= opwr_d;
            err_q      <= err_d;
            memdata_q  <= memdata_d;
            memready_q <= memready_d;
            outport_q  <= outport_d;
            outvalid_q <= outvalid_d;
        end
    end

    mips_ram #(
        .WIDTH(WIDTH)
    ) u_ram (
        .clk        (clk),
        .cpu_we_i   (cpu_we_s),
        .cpu_adr_i  (adr_q),
        .cpu_data_i (wdata_q),
        .ldr_we_i   (ldr_we_s),
        .ldr_adr_i  (ldr_adr),
        .ldr_data_i (ldr_data),
        .rd_adr_i   (adr_d),
        .rd_data_o  (ram_rdata_s)
    );

    assign memdata  = memdata_q;
    assign memready = memready_q;
    assign outport  = outport_q;
    assign outvalid = outvalid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench: one responder with one wait state, one with none.
module tb_mips_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Common request drivers, routed to one DUT by sel0.
    logic       sel0 = 1'b0;
    logic       rd = 1'b0, wr = 1'b0, len = 1'b0;
    logic [7:0] adr = 8'h00, wd = 8'h00, ladr = 8'h00, ldat = 8'h00;

    logic [7:0] md1, op1, md0, op0;
    logic       mr1, ov1, er1, mr0, ov0, er0;

    mips_mem_responder #(.WIDTH(8), .WAIT_STATES(1), .OUTADR(8'hFF)) dut1 (
        .clk(clk), .reset(reset),
        .memread(rd & ~sel0), .memwrite(wr & ~sel0),
        .adr(adr), .writedata(wd),
        .memdata(md1), .memready(mr1), .outport(op1), .outvalid(ov1), .err(er1),
        .ldr_en(len & ~sel0), .ldr_adr(ladr), .ldr_data(ldat)
    );

    mips_mem_responder #(.WIDTH(8), .WAIT_STATES(0), .OUTADR(8'hFF)) dut0 (
        .clk(clk), .reset(reset),
        .memread(rd & sel0), .memwrite(wr & sel0),
        .adr(adr), .writedata(wd),
        .memdata(md0), .memready(mr0), .outport(op0), .outvalid(ov0), .err(er0),
        .ldr_en(len & sel0), .ldr_adr(ladr), .ldr_data(ldat)
    );

    logic [7:0] m_data, m_op;
    logic       m_ready, m_ov, m_err;
    assign m_data  = sel0 ? md0 : md1;
    assign m_op    = sel0 ? op0 : op1;
    assign m_ready = sel0 ? mr0 : mr1;
    assign m_ov    = sel0 ? ov0 : ov1;
    assign m_err   = sel0 ? er0 : er1;

    int checks = 0;
    int failures = 0;
    int pulses0 = 0;

    // Count memready pulses of the zero-wait DUT to detect lost/duplicate responses.
    always @(negedge clk) begin
        if (mr0) pulses0 <= pulses0 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Loader write performed while the selected DUT is idle.
    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        len = 1'b1; ladr = a; ldat = d;
        @(negedge clk);
        len = 1'b0;
    endtask

    // One CPU request, started at a negedge. Latency counts the edges after
    // acceptance up to the one where the requester sees memready.
    task automatic do_req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic ldr_mid, input logic [7:0] la, input logic [7:0] ld,
                          output int lat, output logic [7:0] md, output logic ov,
                          output logic [7:0] op, output logic e);
        logic ok;
        rd = r; wr = w; adr = a; wd = d;
        @(posedge clk); #1;
        adr = ~a; wd = ~d;
        if (ldr_mid) begin
            len = 1'b1; ladr = la; ldat = ld;
        end
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (m_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL timeout actual=no_memready required=memready");
        end
        md = m_data; ov = m_ov; op = m_op; e = m_err;
        rd = 1'b0; wr = 1'b0; len = 1'b0;
    endtask

    // The response must be a single-cycle pulse.
    task automatic chk_pulse(input string nm);
        @(negedge clk);
        chk({nm, "_ready_width"}, m_ready, 1'b0);
        chk({nm, "_ov_width"}, m_ov, 1'b0);
    endtask

    typedef struct {
        logic       r;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
        logic [7:0] md;
        logic       ov;
        logic [7:0] op;
        logic       e;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int lat;
        logic [7:0] md, op;
        logic ov, e;
        int base;

        tbl[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 2, 8'h5A, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hFF, 8'h0D, 2, 8'h5A, 1'b1, 8'h0D, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2, 8'h0D, 1'b0, 8'h0D, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h40, 8'hC3, 2, 8'h0D, 1'b0, 8'h0D, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h40, 8'h00, 2, 8'hC3, 1'b0, 8'h0D, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h20, 8'h33, 2, 8'hC3, 1'b0, 8'h0D, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 8'h20, 8'h00, 2, 8'h33, 1'b0, 8'h0D, 1'b1};

        // Reset state of both instances.
        #12;
        chk("rst_memdata1", md1, 8'h00);  chk("rst_memready1", mr1, 1'b0);
        chk("rst_outport1", op1, 8'h00);  chk("rst_outvalid1", ov1, 1'b0);
        chk("rst_err1", er1, 1'b0);
        chk("rst_memdata0", md0, 8'h00);  chk("rst_memready0", mr0, 1'b0);
        chk("rst_outport0", op0, 8'h00);  chk("rst_outvalid0", ov0, 1'b0);
        chk("rst_err0", er0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // One wait state: table of requests after a preload.
        load(8'h10, 8'h5A);
        for (int i = 0; i < 7; i++) begin
            do_req(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 8'h00, 8'h00, lat, md, ov, op, e);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_memdata", i), md, tbl[i].md);
            chk($sformatf("v%0d_outvalid", i), ov, tbl[i].ov);
            chk($sformatf("v%0d_outport", i), op, tbl[i].op);
            chk($sformatf("v%0d_err", i), e, tbl[i].e);
            chk_pulse($sformatf("v%0d", i));
        end

        // Loader pulse during WAIT must be dropped.
        load(8'h50, 8'h11);
        do_req(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h50, 8'h99, lat, md, ov, op, e);
        chk("ldrmid_read", md, 8'h5A);
        chk_pulse("ldrmid");
        do_req(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 8'h00, lat, md, ov, op, e);
        chk("ldrmid_kept", md, 8'h11);
        chk_pulse("ldrmid2");

        // Reset during WAIT of a write aborts it.
        load(8'h30, 8'h77);
        rd = 1'b0; wr = 1'b1; adr = 8'h30; wd = 8'hAA;
        @(posedge clk); #1;
        reset = 1'b0;
        wr = 1'b0;
        #1;
        chk("abort_memdata", md1, 8'h00);  chk("abort_memready", mr1, 1'b0);
        chk("abort_outport", op1, 8'h00);  chk("abort_outvalid", ov1, 1'b0);
        chk("abort_err", er1, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        base = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mr1) base++;
        end
        chk("abort_no_ready", base, 0);
        do_req(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 8'h00, lat, md, ov, op, e);
        chk("abort_unchanged", md, 8'h77);
        chk("abort_err_after", e, 1'b0);
        chk_pulse("abort");

        // Zero wait states: back-to-back reads.
        sel0 = 1'b1;
        load(8'h00, 8'hA1);
        load(8'h01, 8'hB2);
        #1 base = pulses0;
        @(negedge clk);
        do_req(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, lat, md, ov, op, e);
        chk("ws0_r0_latency", lat, 1);
        chk("ws0_r0_data", md, 8'hA1);
        chk_pulse("ws0_r0");
        do_req(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, lat, md, ov, op, e);
        chk("ws0_r1_latency", lat, 1);
        chk("ws0_r1_data", md, 8'hB2);
        chk_pulse("ws0_r1");
        repeat (4) @(negedge clk);
        #1;
        chk("ws0_pulse_count", pulses0 - base, 2);
        chk("ws0_err", er0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
